// File: rtl/spm_product_deserializer.sv
// Serial-to-parallel capture of an SPM product stream (LSB first), held
// with a valid/ready handshake until downstream accepts it.
module spm_product_deserializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               bit_in,
  input  logic               ready,
  output logic [2*WIDTH-1:0] product,
  output logic               valid,
  output logic               busy
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(PW);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] shifted;

  // New bit enters at the MSB so bit 0 lands in product[0] after 2W edges.
  assign shifted = {bit_in, product[PW-1:1]};

  // valid/busy are registered alongside state so they never see inputs combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      product <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            product <= shifted;
            cnt     <= CNT_ONE;
            state   <= SHIFT;
            busy    <= 1'b1;
          end
        end

        SHIFT: begin
          product <= shifted;
          if (cnt == CNT_LAST) begin
            // Counter stays at its last value so it never wraps.
            state <= HOLD;
            busy  <= 1'b0;
            valid <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        HOLD: begin
          if (ready) begin
            valid <= 1'b0;
            if (start) begin
              product <= shifted;
              cnt     <= CNT_ONE;
              state   <= SHIFT;
              busy    <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          valid <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spm_product_deserializer.sv
// Directed self-checking bench for spm_product_deserializer at WIDTH=8.
module tb_spm_product_deserializer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned PW    = 2 * WIDTH;

  logic          clk;
  logic          rst;
  logic          start;
  logic          bit_in;
  logic          ready;
  logic [PW-1:0] product;
  logic          valid;
  logic          busy;

  int n_checks;
  int n_fail;
  logic [PW-1:0] cur;

  spm_product_deserializer #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bit_in (bit_in),
    .ready  (ready),
    .product(product),
    .valid  (valid),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  // First edge of a capture: start with product bit 0.
  task automatic stream_start(input logic [PW-1:0] v);
    cur    = v;
    start  = 1'b1;
    bit_in = v[0];
    tick();
    start  = 1'b0;
  endtask

  // Remaining 2W-1 bits; optional spurious start pulse on bit index spur_at.
  task automatic stream_rest(input int spur_at, input logic chk_busy);
    for (int i = 1; i < int'(PW); i++) begin
      bit_in = cur[i];
      start  = (i == spur_at);
      tick();
      start  = 1'b0;
      if (chk_busy && i < int'(PW) - 1) begin
        n_checks++;
        if (busy !== 1'b1 || valid !== 1'b0) begin
          n_fail++;
          $display("FAIL shift_flags bit %0d: busy=%b valid=%b, required busy=1 valid=0", i, busy, valid);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; bit_in = 1'b0; ready = 1'b0;
    #2;
    for (int i = 0; i < 4; i++) begin
      start  = ~start;
      bit_in = ~bit_in;
      tick();
      n_checks++;
      if (product !== 16'h0000 || valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state %0d: product=%h valid=%b busy=%b, required 0000/0/0", i, product, valid, busy);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_basic();
    // Release reset and start on the very next edge.
    rst   = 1'b1;
    ready = 1'b1;
    stream_start(16'h26AC);
    n_checks++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_first_busy: busy=%b valid=%b, required busy=1 valid=0", busy, valid);
    end
    stream_rest(-1, 1'b1);
    n_checks++;
    if (valid !== 1'b1 || busy !== 1'b0 || product !== 16'h26AC) begin
      n_fail++;
      $display("FAIL basic_done: valid=%b busy=%b product=%h, required 1/0/26ac", valid, busy, product);
    end
    tick();
    n_checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_accept: valid=%b busy=%b, required 0/0", valid, busy);
    end
    bit_in = 1'b1;
    tick(); tick();
    n_checks++;
    if (product !== 16'h26AC || valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: product=%h valid=%b busy=%b, required 26ac/0/0", product, valid, busy);
    end
  endtask

  task automatic test_backpressure();
    ready = 1'b0;
    stream_start(16'hFE01);
    stream_rest(-1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (valid !== 1'b1 || busy !== 1'b0 || product !== 16'hFE01) begin
        n_fail++;
        $display("FAIL hold_stable %0d: valid=%b busy=%b product=%h, required 1/0/fe01", i, valid, busy, product);
      end
      start  = ~start;
      bit_in = ~bit_in;
      tick();
    end
    start = 1'b0;
    n_checks++;
    if (valid !== 1'b1 || product !== 16'hFE01) begin
      n_fail++;
      $display("FAIL hold_final: valid=%b product=%h, required 1/fe01", valid, product);
    end
    ready = 1'b1;
    tick();
    n_checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || product !== 16'hFE01) begin
      n_fail++;
      $display("FAIL hold_release: valid=%b busy=%b product=%h, required 0/0/fe01", valid, busy, product);
    end
    ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    ready = 1'b0;
    stream_start(16'hC3F0);
    stream_rest(-1, 1'b0);
    n_checks++;
    if (valid !== 1'b1 || product !== 16'hC3F0) begin
      n_fail++;
      $display("FAIL b2b_first: valid=%b product=%h, required 1/c3f0", valid, product);
    end
    ready = 1'b1;
    stream_start(16'h0001);
    n_checks++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_restart: busy=%b valid=%b, required 1/0", busy, valid);
    end
    ready = 1'b0;
    stream_rest(-1, 1'b1);
    n_checks++;
    if (valid !== 1'b1 || busy !== 1'b0 || product !== 16'h0001) begin
      n_fail++;
      $display("FAIL b2b_second: valid=%b busy=%b product=%h, required 1/0/0001", valid, busy, product);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  task automatic test_spurious_start();
    stream_start(16'h1234);
    stream_rest(7, 1'b1);
    n_checks++;
    if (valid !== 1'b1 || busy !== 1'b0 || product !== 16'h1234) begin
      n_fail++;
      $display("FAIL spurious: valid=%b busy=%b product=%h, required 1/0/1234", valid, busy, product);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    stream_start(16'h5555);
    for (int i = 1; i < 9; i++) begin
      bit_in = cur[i];
      tick();
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || product !== 16'h0000) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b busy=%b product=%h, required 0/0/0000", valid, busy, product);
    end
    tick();
    rst = 1'b1;
    bit_in = 1'b1;
    tick(); tick();
    n_checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || product !== 16'h0000) begin
      n_fail++;
      $display("FAIL post_reset_idle: valid=%b busy=%b product=%h, required 0/0/0000", valid, busy, product);
    end
    stream_start(16'h00FF);
    stream_rest(-1, 1'b1);
    n_checks++;
    if (valid !== 1'b1 || busy !== 1'b0 || product !== 16'h00FF) begin
      n_fail++;
      $display("FAIL reset_recover: valid=%b busy=%b product=%h, required 1/0/00ff", valid, busy, product);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cur      = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_spurious_start();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
